wb_port_arbiter: RTL and testbench

Shares the single register-file write port among the execute-stage functional units: arithmetic unit, multiply unit, divide unit and load-store unit. Each unit hands over a completed result (destination register and data) through a valid/ready handshake into a one-entry holding slot. Occupied slots are granted round-robin, subject to a same-destination age rule that keeps write-after-write order. The granted result drives a registered write port into the register file.

---
 rtl/rv32i_types_pkg.sv | 18 +
 rtl/wb_port_arbiter_rr_arbiter.sv | 46 ++++
 rtl/wb_port_arbiter.sv | 151 +++++++++++++++
 tb/tb_wb_port_arbiter.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/rv32i_types_pkg.sv
// Shared execute-stage types: write-back request record and unit indices.
package rv32i_types_pkg;

  localparam int DATA_W  = 32;
  localparam int REG_W   = 5;
  localparam int NUM_REQ = 4;

  typedef struct packed {
    logic [REG_W-1:0]  rd;
    logic [DATA_W-1:0] wdata;
  } wb_req_t;

  localparam int WB_ALU = 0;
  localparam int WB_MUL = 1;
  localparam int WB_DIV = 2;
  localparam int WB_LSU = 3;

endpackage

// File: rtl/wb_port_arbiter_rr_arbiter.sv
// Round-robin arbiter: one-hot grant to the first requester at or after ptr.
module rr_arbiter
  import rv32i_types_pkg::*;
#(
  parameter int N = 4
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic [N-1:0] req,
  input  logic         advance,
  output logic [N-1:0] grant
);

  localparam int PW = (N > 1) ? $clog2(N) : 1;

  logic [PW-1:0] ptr;
  logic [PW-1:0] ptr_nxt;
  logic [PW-1:0] idx;
  logic          found;

  // Scan requesters starting at ptr; the first hit wins and sets the next start point.
  always_comb begin
    grant   = '0;
    ptr_nxt = ptr;
    found   = 1'b0;
    idx     = '0;
    for (int k = 0; k < N; k++) begin
      idx = PW'((int'(ptr) + k) % N);
      if (!found && req[idx]) begin
        grant[idx] = 1'b1;
        found      = 1'b1;
        ptr_nxt    = PW'((int'(idx) + 1) % N);
      end
    end
  end

  // Pointer only moves past a slot that was actually granted.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      ptr <= '0;
    end else if (advance && found) begin
      ptr <= ptr_nxt;
    end
  end

endmodule

// File: rtl/wb_port_arbiter.sv
// Register-file write-port arbiter: one holding slot per functional unit,
// age matrix to keep same-destination writes in acceptance order, and a
// registered write port.
module wb_port_arbiter
  import rv32i_types_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 32,
  parameter int REG_W   = 5
) (
  input  logic                              CLK,
  input  logic                              RST,
  input  logic                              flush,
  input  logic [NUM_REQ-1:0]                req_valid,
  input  logic [NUM_REQ-1:0][REG_W-1:0]     req_rd,
  input  logic [NUM_REQ-1:0][DATA_W-1:0]    req_wdata,
  output logic [NUM_REQ-1:0]                req_ready,
  output logic                              rf_wen,
  output logic [REG_W-1:0]                  rf_rd,
  output logic [DATA_W-1:0]                 rf_wdata,
  output logic                              busy
);

  logic [NUM_REQ-1:0]                occ;
  logic [NUM_REQ-1:0][REG_W-1:0]     slot_rd;
  logic [NUM_REQ-1:0][DATA_W-1:0]    slot_wdata;
  // older[i][j] = 1 means slot i's entry was accepted before slot j's entry
  logic [NUM_REQ-1:0][NUM_REQ-1:0]   older;
  logic [NUM_REQ-1:0][NUM_REQ-1:0]   older_nxt;
  logic [NUM_REQ-1:0]                eligible;
  logic [NUM_REQ-1:0]                arb_req;
  logic [NUM_REQ-1:0]                grant;
  logic [NUM_REQ-1:0]                load;
  logic [NUM_REQ-1:0]                remain;
  logic [REG_W-1:0]                  gnt_rd;
  logic [DATA_W-1:0]                 gnt_wdata;

  // A slot is blocked while an older occupied slot targets the same register.
  always_comb begin
    eligible = occ;
    for (int i = 0; i < NUM_REQ; i++) begin
      for (int j = 0; j < NUM_REQ; j++) begin
        if (j != i && occ[j] && older[j][i] && slot_rd[j] == slot_rd[i]) begin
          eligible[i] = 1'b0;
        end
      end
    end
  end

  // Flush suppresses the grant so that the pointer holds and nothing is written.
  assign arb_req = flush ? '0 : eligible;

  rr_arbiter #(.N(NUM_REQ)) u_arb (
    .CLK     (CLK),
    .RST     (RST),
    .req     (arb_req),
    .advance (|grant),
    .grant   (grant)
  );

  assign req_ready = flush ? '0 : (~occ | grant);
  assign remain    = occ & ~grant;

  // Writes to x0 complete the handshake but never occupy a slot.
  always_comb begin
    load = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      load[i] = req_valid[i] && req_ready[i] && (req_rd[i] != '0);
    end
  end

  // New entries are younger than every surviving entry; simultaneous loads order by index.
  always_comb begin
    older_nxt = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      for (int j = 0; j < NUM_REQ; j++) begin
        if (i != j) begin
          if (load[j]) begin
            older_nxt[i][j] = remain[i] || (load[i] && i < j);
          end else if (load[i]) begin
            older_nxt[i][j] = 1'b0;
          end else begin
            older_nxt[i][j] = older[i][j] && remain[i] && remain[j];
          end
        end
      end
    end
  end

  // Select the granted slot's contents (grant is one-hot or zero).
  always_comb begin
    gnt_rd    = '0;
    gnt_wdata = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) begin
        gnt_rd    = gnt_rd | slot_rd[i];
        gnt_wdata = gnt_wdata | slot_wdata[i];
      end
    end
  end

  // Holding slots: load on transfer, free on grant, cleared by flush.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      occ        <= '0;
      slot_rd    <= '0;
      slot_wdata <= '0;
    end else if (flush) begin
      occ <= '0;
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (load[i]) begin
          occ[i]        <= 1'b1;
          slot_rd[i]    <= req_rd[i];
          slot_wdata[i] <= req_wdata[i];
        end else if (grant[i]) begin
          occ[i] <= 1'b0;
        end
      end
    end
  end

  // Age matrix register.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      older <= '0;
    end else if (flush) begin
      older <= '0;
    end else begin
      older <= older_nxt;
    end
  end

  // Registered write port; destination and data hold when nothing is granted.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      rf_wen   <= 1'b0;
      rf_rd    <= '0;
      rf_wdata <= '0;
    end else begin
      rf_wen <= |grant;
      if (|grant) begin
        rf_rd    <= gnt_rd;
        rf_wdata <= gnt_wdata;
      end
    end
  end

  assign busy = (|occ) || rf_wen;

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Directed bench for wb_port_arbiter: vector table plus round-robin and reset sequences.
module tb_wb_port_arbiter;

  logic             CLK = 1'b0;
  logic             RST;
  logic             flush;
  logic [3:0]       req_valid;
  logic [3:0][4:0]  req_rd;
  logic [3:0][31:0] req_wdata;
  logic [3:0]       req_ready;
  logic             rf_wen;
  logic [4:0]       rf_rd;
  logic [31:0]      rf_wdata;
  logic             busy;

  int n_vec = 0;
  int n_err = 0;

  wb_port_arbiter #(.NUM_REQ(4), .DATA_W(32), .REG_W(5)) dut (
    .CLK       (CLK),
    .RST       (RST),
    .flush     (flush),
    .req_valid (req_valid),
    .req_rd    (req_rd),
    .req_wdata (req_wdata),
    .req_ready (req_ready),
    .rf_wen    (rf_wen),
    .rf_rd     (rf_rd),
    .rf_wdata  (rf_wdata),
    .busy      (busy)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [3:0]       valid;
    logic             flush;
    logic [3:0][4:0]  rd;
    logic [3:0][31:0] wd;
    logic [3:0]       e_ready;
    logic             e_wen;
    logic [4:0]       e_rd;
    logic [31:0]      e_wd;
    logic             e_busy;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic [3:0] v, logic f, logic [19:0] rd, logic [127:0] wd,
                              logic [3:0] er, logic ew, logic [4:0] erd, logic [31:0] ewd,
                              logic eb);
    vec_t t;
    t.valid = v;  t.flush = f;  t.rd = rd;  t.wd = wd;
    t.e_ready = er;  t.e_wen = ew;  t.e_rd = erd;  t.e_wd = ewd;  t.e_busy = eb;
    return t;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive_idle();
    req_valid = '0;
    req_rd    = '0;
    req_wdata = '0;
    flush     = 1'b0;
  endtask

  int s[4];

  initial begin
    RST = 1'b1;
    drive_idle();
    #2;
    chk("reset.wen",   32'(rf_wen),    32'h0);
    chk("reset.rd",    32'(rf_rd),     32'h0);
    chk("reset.wdata", rf_wdata,       32'h0);
    chk("reset.busy",  32'(busy),      32'h0);
    chk("reset.ready", 32'(req_ready), 32'hF);
    @(negedge CLK);
    @(negedge CLK);
    RST = 1'b0;

    // single result, then ptr to 3 via unit 2
    vecs.push_back(mk(4'b0001, 0, {5'd0,5'd0,5'd0,5'd5}, {96'h0, 32'hDEADBEEF}, 4'hF, 0, 5'd0, 32'h0, 1));
    vecs.push_back(mk(4'b0000, 0, 20'h0, 128'h0, 4'hF, 1, 5'd5, 32'hDEADBEEF, 1));
    vecs.push_back(mk(4'b0000, 0, 20'h0, 128'h0, 4'hF, 0, 5'd5, 32'hDEADBEEF, 0));
    vecs.push_back(mk(4'b0100, 0, {5'd0,5'd2,5'd0,5'd0}, {32'h0, 32'h22, 64'h0}, 4'hF, 0, 5'd5, 32'hDEADBEEF, 1));
    vecs.push_back(mk(4'b0000, 0, 20'h0, 128'h0, 4'hF, 1, 5'd2, 32'h22, 1));
    // WAW: unit 2 rd7/A, then unit 0 rd7/B; unit 0 must wait for A with ptr at 0
    vecs.push_back(mk(4'b1100, 0, {5'd3,5'd7,5'd0,5'd0}, {32'h33, 32'hAAAA, 64'h0}, 4'hF, 0, 5'd2, 32'h22, 1));
    vecs.push_back(mk(4'b0001, 0, {5'd0,5'd0,5'd0,5'd7}, {96'h0, 32'hBBBB}, 4'b1011, 1, 5'd3, 32'h33, 1));
    vecs.push_back(mk(4'b0000, 0, 20'h0, 128'h0, 4'b1110, 1, 5'd7, 32'hAAAA, 1));
    vecs.push_back(mk(4'b0000, 0, 20'h0, 128'h0, 4'hF, 1, 5'd7, 32'hBBBB, 1));
    // same-cycle same-rd: units 1 and 3 both rd9
    vecs.push_back(mk(4'b1010, 0, {5'd9,5'd0,5'd9,5'd0}, {32'h33333333, 32'h0, 32'h11111111, 32'h0}, 4'hF, 0, 5'd7, 32'hBBBB, 1));
    vecs.push_back(mk(4'b0000, 0, 20'h0, 128'h0, 4'b0111, 1, 5'd9, 32'h11111111, 1));
    vecs.push_back(mk(4'b0000, 0, 20'h0, 128'h0, 4'hF, 1, 5'd9, 32'h33333333, 1));
    // x0 offer: accepted, dropped
    vecs.push_back(mk(4'b0010, 0, 20'h0, {64'h0, 32'hFFFF, 32'h0}, 4'hF, 0, 5'd9, 32'h33333333, 0));
    vecs.push_back(mk(4'b0000, 0, 20'h0, 128'h0, 4'hF, 0, 5'd9, 32'h33333333, 0));
    // flush with all four slots full
    vecs.push_back(mk(4'b1111, 0, {5'd4,5'd3,5'd2,5'd1}, {32'h44, 32'h33, 32'h22, 32'h11}, 4'hF, 0, 5'd9, 32'h33333333, 1));
    vecs.push_back(mk(4'b1111, 1, {5'd4,5'd3,5'd2,5'd1}, {32'h44, 32'h33, 32'h22, 32'h11}, 4'h0, 0, 5'd9, 32'h33333333, 0));
    vecs.push_back(mk(4'b0000, 0, 20'h0, 128'h0, 4'hF, 0, 5'd9, 32'h33333333, 0));

    foreach (vecs[i]) begin
      @(negedge CLK);
      req_valid = vecs[i].valid;
      flush     = vecs[i].flush;
      req_rd    = vecs[i].rd;
      req_wdata = vecs[i].wd;
      #1;
      chk($sformatf("v%0d.ready", i), 32'(req_ready), 32'(vecs[i].e_ready));
      @(posedge CLK);
      #1;
      chk($sformatf("v%0d.wen", i),   32'(rf_wen),   32'(vecs[i].e_wen));
      chk($sformatf("v%0d.rd", i),    32'(rf_rd),    32'(vecs[i].e_rd));
      chk($sformatf("v%0d.wdata", i), rf_wdata,      vecs[i].e_wd);
      chk($sformatf("v%0d.busy", i),  32'(busy),     32'(vecs[i].e_busy));
    end

    // round-robin streaming: every unit offers continuously, rd = unit+1
    for (int u = 0; u < 4; u++) s[u] = 0;
    for (int m = 0; m < 12; m++) begin
      logic [3:0] hs;
      @(negedge CLK);
      flush = 1'b0;
      req_valid = 4'hF;
      for (int u = 0; u < 4; u++) begin
        req_rd[u]    = 5'(u + 1);
        req_wdata[u] = 32'((u << 16) | s[u]);
      end
      #1;
      if (m == 0) chk("rr.ready0", 32'(req_ready), 32'hF);
      else        chk($sformatf("rr%0d.ready", m), 32'(req_ready), 32'(1 << ((m - 1) % 4)));
      hs = req_valid & req_ready;
      @(posedge CLK);
      #1;
      for (int u = 0; u < 4; u++) if (hs[u]) s[u]++;
      if (m == 0) begin
        chk("rr0.wen", 32'(rf_wen), 32'h0);
      end else begin
        chk($sformatf("rr%0d.wen", m),   32'(rf_wen), 32'h1);
        chk($sformatf("rr%0d.rd", m),    32'(rf_rd),  32'((m - 1) % 4 + 1));
        chk($sformatf("rr%0d.wdata", m), rf_wdata,    32'((((m - 1) % 4) << 16) | ((m - 1) / 4)));
      end
    end

    // stop offering: one more grant leaves three slots occupied, then reset mid-stream
    @(negedge CLK);
    drive_idle();
    @(posedge CLK);
    #1;
    chk("pre_rst.wen",  32'(rf_wen), 32'h1);
    chk("pre_rst.busy", 32'(busy),   32'h1);
    @(negedge CLK);
    RST = 1'b1;
    #1;
    chk("rst.wen",   32'(rf_wen),    32'h0);
    chk("rst.rd",    32'(rf_rd),     32'h0);
    chk("rst.busy",  32'(busy),      32'h0);
    chk("rst.ready", 32'(req_ready), 32'hF);
    @(negedge CLK);
    RST = 1'b0;
    for (int k = 0; k < 2; k++) begin
      @(posedge CLK);
      #1;
      chk($sformatf("post_rst%0d.wen", k),   32'(rf_wen),    32'h0);
      chk($sformatf("post_rst%0d.busy", k),  32'(busy),      32'h0);
      chk($sformatf("post_rst%0d.ready", k), 32'(req_ready), 32'hF);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
